// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-outstanding load/store unit between the core pipeline and a
// word-wide memory bus. Latches the request, drives byte enables / replicated
// store data, stalls the core until completion or bus timeout, then extends the
// returned load data.
// Optional build macro LSU_MISALIGN_CHECK_EN: misaligned H/HU/W accesses are
// rejected without a bus cycle and flagged on misalign_o.
module lsu_ctrl #(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        bus_err_o,
  output logic        misalign_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // Only what the load-extension path needs after the request is gone.
  typedef struct packed {
    logic       we;
    logic [2:0] size;
    logic [1:0] offs;
  } req_t;

  localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  // Counter value seen in the last BUSY cycle before a timeout.
  localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

  state_t          state, stateNext;
  req_t            lat;
  logic [CW-1:0]   waitCnt;
  logic            timeout;
  logic            misalignReq;
  logic            startBus;
  logic [3:0]      coreBe;
  logic [31:0]     coreWd;
  logic [31:0]     loadData;
  logic [7:0]      selB;
  logic [15:0]     selH;

  // Sizes: low two bits pick byte/half/word (3,6,7 fall into word), bit 2 = unsigned.
  function automatic logic isByte(input logic [2:0] s);
    return s[1:0] == 2'b00;
  endfunction

  function automatic logic isHalf(input logic [2:0] s);
    return s[1:0] == 2'b01;
  endfunction

`ifdef LSU_MISALIGN_CHECK_EN
  assign misalignReq = (isHalf(core_size_i) && core_addr_i[0]) ||
                       (!isByte(core_size_i) && !isHalf(core_size_i) && (core_addr_i[1:0] != 2'b00));
`else
  assign misalignReq = 1'b0;
`endif

  assign startBus = (state == IDLE) && core_req_i && !misalignReq;
  // Ready in the same cycle as the last allowed wait cycle wins over the timeout.
  assign timeout  = (MAX_WAIT != 0) && (state == BUSY) && !mem_ready_i && (waitCnt == WAIT_LAST);

  assign mem_req_o = (state == BUSY);
  assign mem_we_o  = (state == BUSY) && lat.we;

  // Byte enables and lane-replicated store data for the incoming request.
  always_comb begin
    coreBe = 4'b1111;
    coreWd = core_wd_i;
    if (isByte(core_size_i)) begin
      coreBe = 4'b0001 << core_addr_i[1:0];
      coreWd = {4{core_wd_i[7:0]}};
    end else if (isHalf(core_size_i)) begin
      coreBe = 4'b0011 << {core_addr_i[1], 1'b0};
      coreWd = {2{core_wd_i[15:0]}};
    end
  end

  // Lane select and sign/zero extension of the returned word.
  always_comb begin
    selB = mem_rd_i[7:0];
    case (lat.offs)
      2'd1:    selB = mem_rd_i[15:8];
      2'd2:    selB = mem_rd_i[23:16];
      2'd3:    selB = mem_rd_i[31:24];
      default: selB = mem_rd_i[7:0];
    endcase
    selH = lat.offs[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
    if (isByte(lat.size))
      loadData = {{24{~lat.size[2] & selB[7]}}, selB};
    else if (isHalf(lat.size))
      loadData = {{16{~lat.size[2] & selH[15]}}, selH};
    else
      loadData = mem_rd_i;
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= stateNext;
  end

  // Next state and core stall.
  always_comb begin
    stateNext    = state;
    core_stall_o = 1'b0;
    case (state)
      IDLE: if (core_req_i) begin
        core_stall_o = 1'b1;
        stateNext    = misalignReq ? DONE : BUSY;
      end
      BUSY: begin
        core_stall_o = 1'b1;
        if (mem_ready_i || timeout) stateNext = DONE;
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Request latch, wait counter, load result and error pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lat        <= '0;
      mem_addr_o <= '0;
      mem_be_o   <= '0;
      mem_wd_o   <= '0;
      waitCnt    <= '0;
      core_rd_o  <= '0;
      bus_err_o  <= 1'b0;
    end else begin
      if (startBus) begin
        lat        <= '{we: core_we_i, size: core_size_i, offs: core_addr_i[1:0]};
        mem_addr_o <= {core_addr_i[31:2], 2'b00};
        mem_be_o   <= coreBe;
        mem_wd_o   <= coreWd;
        waitCnt    <= '0;
      end else if (state == BUSY && !mem_ready_i) begin
        waitCnt <= waitCnt + 1'b1;
      end
      bus_err_o <= timeout;
      if (state == BUSY && mem_ready_i && !lat.we)
        core_rd_o <= loadData;
      else if (timeout || (state == IDLE && core_req_i && misalignReq))
        core_rd_o <= '0;
    end
  end

`ifdef LSU_MISALIGN_CHECK_EN
  // One-cycle flag in the DONE cycle of a rejected access.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) misalign_o <= 1'b0;
    else       misalign_o <= (state == IDLE) && core_req_i && misalignReq;
  end
`else
  assign misalign_o = 1'b0;
`endif

endmodule
